// File: rtl/lsu_wb_arbiter.sv
// lsu_wb_arbiter
//   Arbitrates the LSU load and store request channels onto one Wishbone master.
//   Each transfer is a single Wishbone cycle: IDLE (grant) -> ACCESS (cyc/stb) -> RESP
//   (one-cycle completion pulse to the owner) -> IDLE.
// Ports
//   clk, rstn_i            clock, synchronous active-low reset
//   ld_*_i / ld_*_o        load request (level) and completion (valid/err pulse, read data)
//   st_*_i / st_*_o        store request (level) and completion (valid/err pulse)
//   busy_o                 high whenever not in IDLE
//   wb_*_o / wb_*_i        Wishbone master: adr/dat/sel/we/cyc/stb/lock out,
//                          dat/ack/err/gnt in
module lsu_wb_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rstn_i,
   input  logic        ld_req_i,
   input  logic [31:0] ld_addr_i,
   input  logic [3:0]  ld_be_i,
   output logic        ld_valid_o,
   output logic        ld_err_o,
   output logic [31:0] ld_data_o,
   input  logic        st_req_i,
   input  logic [31:0] st_addr_i,
   input  logic [31:0] st_data_i,
   input  logic [3:0]  st_be_i,
   output logic        st_valid_o,
   output logic        st_err_o,
   output logic        busy_o,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_lock_o,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_ack_i,
   input  logic        wb_err_i,
   input  logic        wb_gnt_i
);

   // A zero timeout still needs a legal one-bit counter; it just never matches.
   localparam int unsigned CntW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e         state_q, state_d;
   logic           owner_q, owner_d;   // 1 = store owns the transfer
   logic           last_q, last_d;     // 1 = store was granted last
   logic [31:0]    adr_q, adr_d;
   logic [31:0]    wdat_q, wdat_d;
   logic [3:0]     be_q, be_d;
   logic           err_q, err_d;
   logic [31:0]    ld_data_q, ld_data_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic           grant_st;
   logic           in_access;
   logic           stb;

   assign in_access = (state_q == StAccess);
   assign stb       = in_access & wb_gnt_i;

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      adr_d     = adr_q;
      be_d      = be_q;
      wdat_d    = wdat_q;
      err_d     = err_q;
      cnt_d     = cnt_q;
      ld_data_d = ld_data_q;
      grant_st  = 1'b0;
      case (state_q)
         StIdle: begin
            if (ld_req_i || st_req_i) begin
               // On a tie the requester not granted last time wins.
               grant_st = st_req_i && (!ld_req_i || !last_q);
               owner_d  = grant_st;
               last_d   = grant_st;
               adr_d    = grant_st ? st_addr_i : ld_addr_i;
               be_d     = grant_st ? st_be_i : ld_be_i;
               wdat_d   = st_data_i;
               err_d    = 1'b0;
               cnt_d    = '0;
               state_d  = StAccess;
            end
         end
         StAccess: begin
            if (stb) begin
               if (wb_err_i) begin
                  err_d   = 1'b1;
                  state_d = StResp;
               end else if (wb_ack_i) begin
                  err_d   = 1'b0;
                  state_d = StResp;
                  if (!owner_q) ld_data_d = wb_dat_i;
               end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CntMax)) begin
                  err_d   = 1'b1;
                  state_d = StResp;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn_i) begin
         state_q   <= StIdle;
         owner_q   <= 1'b0;
         last_q    <= 1'b1;
         adr_q     <= '0;
         wdat_q    <= '0;
         be_q      <= '0;
         err_q     <= 1'b0;
         ld_data_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         adr_q     <= adr_d;
         wdat_q    <= wdat_d;
         be_q      <= be_d;
         err_q     <= err_d;
         ld_data_q <= ld_data_d;
         cnt_q     <= cnt_d;
      end
   end

   // Completion pulses decode straight from registered state, so they are glitch-free.
   assign ld_valid_o = (state_q == StResp) && !owner_q;
   assign st_valid_o = (state_q == StResp) && owner_q;
   assign ld_err_o   = ld_valid_o && err_q;
   assign st_err_o   = st_valid_o && err_q;
   assign ld_data_o  = ld_data_q;
   assign busy_o     = (state_q != StIdle);

   assign wb_cyc_o  = in_access;
   assign wb_stb_o  = stb;
   assign wb_we_o   = in_access && owner_q;
   assign wb_adr_o  = in_access ? adr_q : 32'h0;
   assign wb_dat_o  = in_access ? wdat_q : 32'h0;
   assign wb_sel_o  = in_access ? be_q : 4'h0;
   assign wb_lock_o = 1'b0;

endmodule
